// File: rtl/bram_fifo_pkg.sv
// Shared constants and types for the BlockRAM-backed FIFO controller.
package bram_fifo_pkg;
  localparam int DFLT_WE_BIT     = 20;
  localparam int DFLT_WR_MSB_BIT = 16;
  localparam int DFLT_RD_MSB_BIT = 24;
  localparam int DEPTH           = 512;
  localparam int PTR_W           = 10;
  localparam int DATA_W          = 16;
  localparam int LVL_W           = 10;
  // 16-bit write, 16-bit read, dynamic WE, no RAM output register
  localparam logic [5:0] RAM_CFG = 6'b001010;

  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/bram_fifo_outbuf.sv
// Two-entry registered output buffer; entry 0 is always the head.
module bram_fifo_outbuf
  import bram_fifo_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] dout
);
  logic [W-1:0] ent0, ent1;

  assign valid = (count != 2'd0);
  assign dout  = ent0;

  // Count and entry update; pop shifts entry 1 into the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) ent0 <= din;
          else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/bram_fifo_ctrl.sv
// 512x16 FIFO controller driving one BlockRAM_1KB with a 1-cycle read.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int WE_BIT     = DFLT_WE_BIT,
  parameter int WR_MSB_BIT = DFLT_WR_MSB_BIT,
  parameter int RD_MSB_BIT = DFLT_RD_MSB_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LVL_W-1:0]  level,
  output logic [5:0]        ram_cfg,
  output logic [7:0]        ram_wr_addr,
  output logic [7:0]        ram_rd_addr,
  output logic [31:0]       ram_wr_data,
  input  logic [31:0]       ram_rd_data
);
  ptr_t       wr_ptr, rd_ptr;
  ptr_t       stored;
  logic       full, push, pop, issue, inflight;
  logic [1:0] buf_count;
  logic [2:0] slots_used;
  logic       unused_rd_hi;

  assign unused_rd_hi = ^ram_rd_data[31:16];

  // Words in RAM not yet read out; a same-cycle push is not in here yet,
  // so a read can never target the row being written this cycle.
  assign stored   = wr_ptr - rd_ptr;
  assign full     = (stored == ptr_t'(DEPTH));
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // A pop this cycle frees a buffer slot for the read issued now.
  assign slots_used = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (stored != '0) && (slots_used < 3'd2);

  assign ram_cfg     = RAM_CFG;
  assign ram_wr_addr = wr_ptr[7:0];
  assign ram_rd_addr = rd_ptr[7:0];

  // RAM write word: data, half selects and dynamic write enable.
  always_comb begin
    ram_wr_data             = '0;
    ram_wr_data[15:0]       = in_data;
    ram_wr_data[WR_MSB_BIT] = wr_ptr[8];
    ram_wr_data[WE_BIT]     = push;
    ram_wr_data[RD_MSB_BIT] = rd_ptr[8];
  end

  // Pointers, read-in-flight flag and occupancy level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      level    <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      level    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ptr_t'(1);
      if (issue) rd_ptr <= rd_ptr + ptr_t'(1);
      inflight <= issue;
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
    end
  end

  // Read data returns the cycle after issue; dropped if a flush intervened.
  bram_fifo_outbuf #(.W(DATA_W)) u_outbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (inflight),
    .din   (ram_rd_data[DATA_W-1:0]),
    .pop   (pop),
    .count (buf_count),
    .valid (out_valid),
    .dout  (out_data)
  );
endmodule

// File: doc/bram_fifo_ctrl.md
# bram_fifo_ctrl

Streaming FIFO controller that drives one BlockRAM_1KB instance as a 512-entry × 16-bit FIFO. It sits directly upstream of the RAM: it accepts a valid/ready write stream, generates the RAM's write address, read address and in-band control bits, and consumes the RAM's 1-cycle read data into a 2-entry output buffer that presents a valid/ready read stream. It is used wherever fabric logic needs deep elastic buffering without hand-managing RAM addressing.

## Interface
- WE_BIT, 20: ram_wr_data bit driven as the RAM's dynamic write enable (1 = write).
- WR_MSB_BIT, 16: LSB of the 2-bit write half-select field in ram_wr_data.
- RD_MSB_BIT, 24: LSB of the 2-bit read half-select field in ram_wr_data.
- clk  in  1  single clock for all logic and the RAM.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- in_valid / in_ready  in/out  1  write-side handshake.
- in_data  in  16  write word.
- out_valid / out_ready  out/in  1  read-side handshake.
- out_data  out  16  read word, valid when out_valid.
- level  out  10  words accepted and not yet popped (0..514).
- ram_cfg  out  6  constant {C5..C0} = 6'b001010 (16-bit write, 16-bit read, dynamic WE, no RAM output register).
- ram_wr_addr / ram_rd_addr  out  8  RAM write/read row.
- ram_wr_data  out  32  [15:0] data, [WR_MSB_BIT+1:WR_MSB_BIT] = {0, half}, [WE_BIT] write enable, [RD_MSB_BIT+1:RD_MSB_BIT] = {0, rd half}; all other bits 0.
- ram_rd_data  in  32  RAM rd_data; only [15:0] used.

## Operation
- Entry index p (9 bits) maps to row p[7:0], half p[8].
- Pointers wr_ptr, rd_ptr are 10 bits (9 index + wrap bit); stored = wr_ptr − rd_ptr (0..512); full when stored == 512.
- in_ready = !full && !flush. Push fires when in_valid && in_ready: same cycle, ram_wr_addr = wr_ptr[7:0], half = wr_ptr[8], ram_wr_data[WE_BIT] = 1; wr_ptr increments at the edge. When no push, WE_BIT = 0.
- Read issue when stored_committed > 0 and (buf_count + inflight) < 2, counting a pop in the same cycle as freeing one slot. stored_committed excludes a word pushed in the current cycle (no same-cycle read of a row being written). Issue drives ram_rd_addr = rd_ptr[7:0], read half bit = rd_ptr[8]; rd_ptr increments; inflight set for one cycle.
- Cycle after issue, ram_rd_data[15:0] is written into the output buffer (FIFO order).
- Output buffer: 2 entries; out_valid = buf_count != 0; out_data = head. Pop when out_valid && out_ready.
- level +1 on push, −1 on pop, unchanged on both.
- Simultaneous push at full and pop: push refused (in_ready depends only on stored, not same-cycle pop).
- Pointer wrap from 1023 to 0 is natural modulo arithmetic.
- flush: at the edge, pointers, buffer, inflight and level clear; a read returning the following cycle is discarded.

## Timing
- Reset (async, rst_n low): wr_ptr = rd_ptr = 0, buffer empty, inflight 0, level 0, out_valid 0, out_data 0, in_ready 1, WE_BIT 0, ram addresses 0.
- First-word latency from empty: push in cycle N, read issued N+1, buffer loaded at end of N+2, out_valid high in N+3.
- Sustained throughput: one push and one pop per cycle once buffer is primed.
- out_data/out_valid are register outputs; in_ready is combinational from registers and flush only.

## Structure
- Package bram_fifo_pkg: WE_BIT/WR_MSB_BIT/RD_MSB_BIT defaults, RAM_CFG constant 6'b001010, DEPTH = 512, PTR_W = 10.
- One sub-module: bram_fifo_outbuf (2-entry registered buffer with count, push/pop, clear).

## Test plan
- Reset then push 0x1234 once, out_ready=1 -> out_valid first high exactly 3 cycles after push, out_data 0x1234, level 1 -> 0.
- Push 514 words 0..513 with out_ready=0 -> in_ready drops after 514th accept, level = 514, ram_wr_data[16] = 1 for words 256..511.
- Continuous push/pop of 2000 incrementing words -> output sequence identical, no gaps after priming, pointers wrap cleanly.
- Full state, in_valid=1 and out_ready=1 same cycle -> pop occurs, push refused that cycle, accepted next cycle.
- Random in_valid/out_ready backpressure over 10k words -> scoreboard match, level always equals pushes − pops.
- flush with 100 words stored and a read in flight -> next cycle out_valid 0, level 0; next pushed word 0xBEEF is the first word out.
